mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-ported memory between the rv32i core's instruction port (read-only) and data port (read/write).
- Sits between the core's mem_i_*/mem_d_* ports and a unified SRAM/bus slave.
- Both sides use the same strobe/busy protocol as the core:
  - A requester holds its strobe until a cycle where busy is low.
  - Read data is valid in that same cycle.
- Arbitration uses a registered grant and costs one cycle of latency per transaction.

Parameters:
- AW, 32, address width.
- DW, 32, data width; the mask width is DW/8.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_addr  in  AW  instruction read address
- i_rstrb  in  1  instruction read request
- i_rdata  out  DW  instruction read data
- i_rbusy  out  1  instruction port busy
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_wmask  in  DW/8  byte write mask
- d_wstrb  in  1  data write request
- d_rstrb  in  1  data read request
- d_rdata  out  DW  data read data
- d_rbusy  out  1  data read busy
- d_wbusy  out  1  data write busy
- mem_addr  out  AW  shared memory address
- mem_wdata  out  DW  shared memory write data
- mem_wmask  out  DW/8  shared memory byte mask
- mem_wstrb  out  1  shared memory write strobe
- mem_rstrb  out  1  shared memory read strobe
- mem_rdata  in  DW  shared memory read data
- mem_busy  in  1  shared memory busy

Behaviour:
- State register, one-hot: IDLE, GNT_I, GNT_D.
- Reset:
  - state = IDLE.
  - mem_rstrb, mem_wstrb = 0; mem_addr, mem_wdata, mem_wmask = 0.
  - Busy outputs follow the combinational rules below.
- Request definitions:
  - req_i = i_rstrb.
  - req_d = d_rstrb | d_wstrb.
- IDLE:
  - No memory strobes are driven.
  - Each port reports busy = 1 whenever its own strobe is high.
  - Next state:
    - Only req_d: GNT_D.
    - Only req_i: GNT_I.
    - Both: GNT_D (fixed priority; see the optional feature).
    - Neither: stay in IDLE.
- GNT_X (X = I or D):
  - mem_* outputs are driven combinationally from port X.
  - Port I muxes its address only; wdata, wmask and wstrb are forced to 0.
  - Port X busy = mem_busy, gated by port X strobe.
  - The non-granted port reports busy = 1 while its strobe is high.
  - Completion is a cycle where X's strobe is high and mem_busy = 0.
    - X sees busy = 0 and samples its rdata that cycle.
    - Next state is decided by the IDLE arbitration rule, excluding X's current request (back-to-back grant allowed, but no bubble is forced).
  - If X's strobe drops before completion (abort): mem strobes deassert that cycle, and next state is IDLE.
- Read data routing: i_rdata = d_rdata = mem_rdata, broadcast; validity is qualified solely by the busy outputs.
- Latency:
  - An uncontended request completes no earlier than 1 cycle after strobe assertion (1 + memory wait states).
  - A request losing a tie waits for the full winner transaction plus 1 cycle.
- Illegal input: d_rstrb and d_wstrb high together; both are forwarded unchanged and no check is made.
- Reset mid-grant: state returns to IDLE and strobes drop on the next edge; the in-flight transaction is dropped.
- Busy outputs are never asserted for a port whose strobe is low.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - A 1-bit last_grant register (reset 0 = I) is updated at each completion.
  - On a tie, the port not served last wins.
- Undefined:
  - Fixed priority: D wins every tie.
  - No last_grant register exists.

Decomposition:
- Shared header mem_arb.vh contains:
  - State one-hot encodings ARB_IDLE, ARB_GNT_I, ARB_GNT_D.
  - Grant-select encoding ARB_SEL_I, ARB_SEL_D.
- One combinational sub-module, mem_arb_pick:
  - Inputs: req_i, req_d, last_grant.
  - Output: grant select.
  - Holds the priority and round-robin rule.
- The FSM, muxing and busy gating stay in mem_arbiter.

Test Plan:
- Lone fetch:
  - Stimulus: i_rstrb=1, i_addr=0x100, mem_busy=0, mem_rdata=0x13.
  - Cycle 0: i_rbusy=1.
  - Cycle 1: mem_rstrb=1, mem_addr=0x100, i_rbusy=0, i_rdata=0x13.
  - Cycle 2: state is IDLE.
- Store with wait states:
  - Stimulus: d_wstrb=1, d_addr=0x2004, d_wmask=4'b0100, mem_busy high for 3 cycles.
  - d_wbusy stays 1 for 4 cycles and mem_wmask=4'b0100 throughout.
  - Completion occurs in cycle 4.
- Tie, fixed priority (macro undefined):
  - Stimulus: i_rstrb and d_rstrb both asserted in cycle 0.
  - D is served in cycle 1.
  - I is re-arbitrated and served in cycle 2 with mem_addr=i_addr.
  - i_rbusy stays 1 through cycle 1.
- Round-robin (MEM_ARB_RR_EN):
  - Stimulus: two consecutive ties.
  - Grant order is D, I, D, I, matching last_grant.
- Abort:
  - Stimulus: d_rstrb dropped in cycle 2 while mem_busy=1.
  - mem_rstrb=0 in that same cycle; state is IDLE next cycle; a pending i_rstrb is granted the cycle after.
- Reset mid-grant:
  - Stimulus: rst pulsed during GNT_D.
  - Next cycle: state IDLE, mem_wstrb=0, mem_rstrb=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// ============================================================================
//  mem_arb_pkg : state and grant-select encodings shared by the memory arbiter
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    // One-hot arbiter states
    localparam logic [2:0] ARB_IDLE  = 3'b001;
    localparam logic [2:0] ARB_GNT_I = 3'b010;
    localparam logic [2:0] ARB_GNT_D = 3'b100;

    // Grant select, also the encoding of the last-served port
    localparam logic ARB_SEL_I = 1'b0;
    localparam logic ARB_SEL_D = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ============================================================================
//  mem_arb_pick : chooses which port to grant from the pending requests.
//                 MEM_ARB_RR_EN selects round-robin tie-breaking, else D wins.
//  Revision     : 1.0
// ============================================================================
`default_nettype none

module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic req_i_i,
    input  logic req_d_i,
    input  logic last_grant_i,
    output logic sel_o
);

    // Result only matters when at least one request is present
    always_comb begin
        sel_o = ARB_SEL_D;
        if (req_i_i && !req_d_i) begin
            sel_o = ARB_SEL_I;
        end
`ifdef MEM_ARB_RR_EN
        else if (req_i_i && req_d_i && (last_grant_i == ARB_SEL_D)) begin
            sel_o = ARB_SEL_I;
        end
`endif
    end

`ifndef MEM_ARB_RR_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
`endif

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  mem_arbiter : shares one single-ported memory between the instruction and
//                data ports of the core. Optional macro: MEM_ARB_RR_EN.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     i_addr,
    input  logic              i_rstrb,
    output logic [DW-1:0]     i_rdata,
    output logic              i_rbusy,
    input  logic [AW-1:0]     d_addr,
    input  logic [DW-1:0]     d_wdata,
    input  logic [DW/8-1:0]   d_wmask,
    input  logic              d_wstrb,
    input  logic              d_rstrb,
    output logic [DW-1:0]     d_rdata,
    output logic              d_rbusy,
    output logic              d_wbusy,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic [DW/8-1:0]   mem_wmask,
    output logic              mem_wstrb,
    output logic              mem_rstrb,
    input  logic [DW-1:0]     mem_rdata,
    input  logic              mem_busy
);

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic       w_req_i;
    logic       w_req_d;
    logic       w_pick_i;
    logic       w_pick_d;
    logic       w_sel;
    logic       w_last_grant;
    logic       w_done_i;
    logic       w_done_d;

    assign w_req_i  = i_rstrb;
    assign w_req_d  = d_rstrb | d_wstrb;
    assign w_done_i = (state_q == ARB_GNT_I) && w_req_i && !mem_busy;
    assign w_done_d = (state_q == ARB_GNT_D) && w_req_d && !mem_busy;

    // The port currently holding the grant is excluded, so a completing
    // grant hands over directly to the other port or falls back to IDLE.
    assign w_pick_i = w_req_i && (state_q != ARB_GNT_I);
    assign w_pick_d = w_req_d && (state_q != ARB_GNT_D);

    mem_arb_pick u_pick (
        .req_i_i      (w_pick_i),
        .req_d_i      (w_pick_d),
        .last_grant_i (w_last_grant),
        .sel_o        (w_sel)
    );

`ifdef MEM_ARB_RR_EN
    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (w_done_i) begin
            last_grant_d = ARB_SEL_I;
        end else if (w_done_d) begin
            last_grant_d = ARB_SEL_D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= ARB_SEL_I;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign w_last_grant = last_grant_q;
`else
    assign w_last_grant = ARB_SEL_I;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (w_pick_i || w_pick_d) begin
                    state_d = (w_sel == ARB_SEL_D) ? ARB_GNT_D : ARB_GNT_I;
                end
            end
            ARB_GNT_I: begin
                if (!w_req_i) begin
                    state_d = ARB_IDLE;
                end else if (!mem_busy) begin
                    state_d = w_pick_d ? ARB_GNT_D : ARB_IDLE;
                end
            end
            ARB_GNT_D: begin
                if (!w_req_d) begin
                    state_d = ARB_IDLE;
                end else if (!mem_busy) begin
                    state_d = w_pick_i ? ARB_GNT_I : ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Strobes follow the granted port combinationally, so an abort
    // drops them in the same cycle the requester lets go.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        mem_wstrb = 1'b0;
        mem_rstrb = 1'b0;
        i_rbusy   = i_rstrb;
        d_rbusy   = d_rstrb;
        d_wbusy   = d_wstrb;
        case (state_q)
            ARB_GNT_I: begin
                mem_addr  = i_addr;
                mem_rstrb = i_rstrb;
                i_rbusy   = i_rstrb & mem_busy;
            end
            ARB_GNT_D: begin
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                mem_wmask = d_wmask;
                mem_wstrb = d_wstrb;
                mem_rstrb = d_rstrb;
                d_rbusy   = d_rstrb & mem_busy;
                d_wbusy   = d_wstrb & mem_busy;
            end
            default: ;
        endcase
    end

    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  tb_mem_arbiter : directed scenarios followed by randomized traffic, every
//                   cycle compared against a transaction-level model.
//  Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] i_addr;
    logic          i_rstrb;
    logic [DW-1:0] i_rdata;
    logic          i_rbusy;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [MW-1:0] d_wmask;
    logic          d_wstrb;
    logic          d_rstrb;
    logic [DW-1:0] d_rdata;
    logic          d_rbusy;
    logic          d_wbusy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [MW-1:0] mem_wmask;
    logic          mem_wstrb;
    logic          mem_rstrb;
    logic [DW-1:0] mem_rdata;
    logic          mem_busy;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_addr    (i_addr),
        .i_rstrb   (i_rstrb),
        .i_rdata   (i_rdata),
        .i_rbusy   (i_rbusy),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wmask   (d_wmask),
        .d_wstrb   (d_wstrb),
        .d_rstrb   (d_rstrb),
        .d_rdata   (d_rdata),
        .d_rbusy   (d_rbusy),
        .d_wbusy   (d_wbusy),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_wstrb (mem_wstrb),
        .mem_rstrb (mem_rstrb),
        .mem_rdata (mem_rdata),
        .mem_busy  (mem_busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level model: who owns the memory this cycle (0 none, 1 I, 2 D)
    int owner  = 0;
    bit last_d = 1'b0;
    bit prev_ib = 1'b0;
    bit prev_db = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int winner(input bit ri, input bit rd);
        if (!ri && !rd) return 0;
        if (ri && !rd) return 1;
        if (!ri && rd) return 2;
`ifdef MEM_ARB_RR_EN
        return last_d ? 1 : 2;
`else
        return 2;
`endif
    endfunction

    // Inputs are already applied; check outputs mid-cycle, then advance model
    task automatic step();
        bit ri;
        bit rd;
        bit ok;
        bit e_ib;
        bit e_drb;
        bit e_dwb;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_wmask;
        bit e_rs;
        bit e_ws;
        @(negedge clk);
        ri = i_rstrb;
        rd = d_rstrb | d_wstrb;
        ok = !mem_busy;
        e_addr  = (owner == 1) ? i_addr : (owner == 2) ? d_addr : 32'h0;
        e_wdata = (owner == 2) ? d_wdata : 32'h0;
        e_wmask = (owner == 2) ? 32'(d_wmask) : 32'h0;
        e_rs    = (owner == 1) ? i_rstrb : (owner == 2) ? d_rstrb : 1'b0;
        e_ws    = (owner == 2) ? d_wstrb : 1'b0;
        e_ib    = i_rstrb && !(owner == 1 && ok);
        e_drb   = d_rstrb && !(owner == 2 && ok);
        e_dwb   = d_wstrb && !(owner == 2 && ok);
        check("mem_addr",  mem_addr,          e_addr);
        check("mem_wdata", mem_wdata,         e_wdata);
        check("mem_wmask", 32'(mem_wmask),    e_wmask);
        check("mem_rstrb", 32'(mem_rstrb),    32'(e_rs));
        check("mem_wstrb", 32'(mem_wstrb),    32'(e_ws));
        check("i_rbusy",   32'(i_rbusy),      32'(e_ib));
        check("d_rbusy",   32'(d_rbusy),      32'(e_drb));
        check("d_wbusy",   32'(d_wbusy),      32'(e_dwb));
        check("i_rdata",   i_rdata,           mem_rdata);
        check("d_rdata",   d_rdata,           mem_rdata);
        prev_ib = e_ib;
        prev_db = e_drb | e_dwb;
        if (rst) begin
            owner  = 0;
            last_d = 1'b0;
        end else if (owner == 0) begin
            owner = winner(ri, rd);
        end else if (owner == 1) begin
            if (!ri) owner = 0;
            else if (ok) begin
                last_d = 1'b0;
                owner  = winner(1'b0, rd);
            end
        end else begin
            if (!rd) owner = 0;
            else if (ok) begin
                last_d = 1'b1;
                owner  = winner(ri, 1'b0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tie_pair();
        i_rstrb = 1'b1; i_addr = 32'h0000_0200;
        d_rstrb = 1'b1; d_addr = 32'h0000_3000;
        mem_busy = 1'b0; mem_rdata = 32'hCAFE_0001;
        step();                         // both busy in IDLE
        step();                         // winner served
        if (owner == 1) d_rstrb = 1'b0; else i_rstrb = 1'b0;
        step();                         // loser served
        i_rstrb = 1'b0; d_rstrb = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        i_addr = '0; i_rstrb = 1'b0;
        d_addr = '0; d_wdata = '0; d_wmask = '0; d_wstrb = 1'b0; d_rstrb = 1'b0;
        mem_rdata = '0; mem_busy = 1'b0;
        @(posedge clk); #1;
        step();
        rst = 1'b0;
        step();

        // Lone fetch
        i_rstrb = 1'b1; i_addr = 32'h100; mem_rdata = 32'h13;
        step();
        step();
        i_rstrb = 1'b0;
        step();

        // Store with three wait states
        d_wstrb = 1'b1; d_addr = 32'h2004; d_wmask = 4'b0100; d_wdata = 32'hA5A5_5A5A;
        step();
        mem_busy = 1'b1;
        repeat (3) step();
        mem_busy = 1'b0;
        step();
        d_wstrb = 1'b0;
        step();

        // Two consecutive ties
        tie_pair();
        tie_pair();

        // Abort of a data read with a fetch pending
        d_rstrb = 1'b1; d_addr = 32'h40;
        step();
        mem_busy = 1'b1;
        step();
        d_rstrb = 1'b0; i_rstrb = 1'b1; i_addr = 32'h180;
        step();
        mem_busy = 1'b0;
        step();
        step();
        i_rstrb = 1'b0;
        step();

        // Reset while data port holds the grant
        d_wstrb = 1'b1; d_addr = 32'h88; d_wmask = 4'hF;
        step();
        mem_busy = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        d_wstrb = 1'b0; mem_busy = 1'b0;
        step();

        // Randomized traffic obeying the strobe/busy handshake
        for (int c = 0; c < 3000; c++) begin
            int k;
            rst = ($urandom_range(0, 63) == 0);
            if (i_rstrb && prev_ib) begin
                if ($urandom_range(0, 19) == 0) i_rstrb = 1'b0;
            end else begin
                i_rstrb = 1'($urandom_range(0, 1));
                i_addr  = $urandom;
            end
            if ((d_rstrb || d_wstrb) && prev_db) begin
                if ($urandom_range(0, 19) == 0) begin
                    d_rstrb = 1'b0;
                    d_wstrb = 1'b0;
                end
            end else begin
                k = int'($urandom_range(0, 4));
                d_rstrb = (k == 1) || (k == 3);
                d_wstrb = (k == 2) || (k == 3);
                d_addr  = $urandom;
                d_wdata = $urandom;
                d_wmask = 4'($urandom);
            end
            mem_busy  = ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
